qpmux_sel_ctrl: RTL and testbench
=================================

// Module: qpmux_sel_ctrl
// PURPOSE
// - Upstream sequencer for the quad-clock mux cell: drives its IS0/IS1 selects and a downstream clock-gate enable.
// - Switches sources break-before-make: gate off, hold, change select, settle, gate on.
// - This stops a select change on IS0/IS1 from glitching the IZ clock.
// - Sits in the clock-control fabric, clocked by a free-running control clock independent of the muxed sources.
// PARAMETERS
// - OFF_CYCLES     4  cycles GATE_EN held low before the select changes (legal 1..255)
// - SETTLE_CYCLES  8  cycles after the select change before GATE_EN re-asserts (legal 1..255)
// - CNT_W          8  width of the internal down-counter; must hold max(OFF_CYCLES, SETTLE_CYCLES)
// PORTS
// - CLK        in   1  control clock; all state on rising edge
// - RST        in   1  asynchronous, active-high reset
// - REQ_VALID  in   1  source-change request valid
// - REQ_SEL    in   2  requested source: 0=QCLKIN, 1=QHSCK, 2=GMUXIN, 3=reserved
// - REQ_READY  out  1  request accepted when REQ_VALID & REQ_READY on a CLK edge
// - IS0        out  1  mux select bit 0 (registered)
// - IS1        out  1  mux select bit 1 (registered)
// - GATE_EN    out  1  downstream clock-gate enable (registered)
// - BUSY       out  1  sequence in progress
// - DONE       out  1  one-cycle pulse on sequence completion
// - CUR_SEL    out  2  source currently applied to IS0/IS1
// - ERR        out  1  sticky reserved-request flag (only with QPMUX_SEL_ERR_EN)
// BEHAVIOUR
// - Encoding: QCLKIN = IS0=0, IS1=0. QHSCK = IS0=0, IS1=1. GMUXIN = IS0=1, IS1=0.
// - Reset values: IS0=0, IS1=0, CUR_SEL=0, GATE_EN=0, DONE=0, ERR=0, REQ_READY=0, BUSY=1.
//   State after reset is SETTLE with counter = SETTLE_CYCLES.
// - FSM states: IDLE, GATE_OFF, SWITCH, SETTLE.
// - IDLE: REQ_READY=1, BUSY=0, GATE_EN=1.
//   - Accept with REQ_SEL==CUR_SEL: no gating; DONE pulses the next cycle; stay in IDLE.
//   - Accept with a different REQ_SEL: latch it, load counter=OFF_CYCLES, go to GATE_OFF. GATE_EN=0 from the next cycle.
// - GATE_OFF: decrement each cycle; on reaching 1, go to SWITCH.
// - SWITCH: one cycle; IS0/IS1/CUR_SEL update at its end; load counter=SETTLE_CYCLES; go to SETTLE.
// - SETTLE: decrement; on reaching 1, go to IDLE. GATE_EN=1 and DONE=1 in the first IDLE cycle.
// - Latency, accept to DONE: OFF_CYCLES + 1 + SETTLE_CYCLES + 1 cycles.
//   GATE_EN is low for OFF_CYCLES + 1 + SETTLE_CYCLES cycles.
// - Flow control: REQ_READY=0 whenever state!=IDLE. REQ_VALID held during BUSY waits; it is not dropped or queued.
// - IS0 and IS1 never change in the same cycle as GATE_EN changes.
//   IS0 and IS1 are never both set for a defined source.
// - Async RST mid-sequence: GATE_EN low at once; select returns to QCLKIN; restart from the reset SETTLE.
// - Simultaneous REQ_VALID and completion: the request is not accepted in the DONE cycle's preceding state.
//   It is accepted in IDLE at the earliest, i.e. the same cycle DONE is high.
// CONFIGURATION
// - Macro QPMUX_SEL_ERR_EN.
// - Defined:
//   - REQ_SEL=3 accepted in IDLE but rejected: no sequence, select unchanged.
//   - ERR set and held until RST; DONE not pulsed.
// - Undefined:
//   - ERR port absent.
//   - REQ_SEL=3 treated as QHSCK (1) for both the compare and the drive.
// STRUCTURE
// - Package qpmux_sel_pkg:
//   - state enum (IDLE, GATE_OFF, SWITCH, SETTLE)
//   - source localparams SRC_QCLKIN=0, SRC_QHSCK=1, SRC_GMUXIN=2, SRC_RSVD=3
//   - function src_to_is(sel) returning {IS1, IS0}
// - Sub-module qpmux_sel_timer: loadable CNT_W down-counter with load, value, en inputs and a hit (count==1) output.
// - Top level holds the FSM and output registers only.
// TESTING
// - Reset release: after SETTLE_CYCLES=8, GATE_EN rises, BUSY falls, IS0=0, IS1=0, no DONE.
// - REQ_SEL=2 from QCLKIN with defaults:
//   - GATE_EN low 13 cycles; IS0 rises 5 cycles after accept; IS1 stays 0; DONE at accept+14.
// - REQ_SEL=0 while CUR_SEL=0: GATE_EN stays high; DONE the next cycle; IS0/IS1 unchanged.
// - REQ_VALID held with REQ_SEL=1 during a busy sequence:
//   - REQ_READY=0 until IDLE; accepted in the DONE cycle; second sequence runs to CUR_SEL=1.
// - RST asserted in the SWITCH cycle of a 0->2 change: IS0=0, GATE_EN=0 immediately; normal recovery after release.
// - REQ_SEL=3:
//   - With QPMUX_SEL_ERR_EN: ERR=1, CUR_SEL unchanged, no DONE.
//   - Without it: sequence completes with IS1=1, IS0=0.

Source files
------------

// File: rtl/qpmux_sel_pkg.sv
// Shared types and helpers for the quad-clock mux select sequencer.
// Optional feature macro used by the top level: QPMUX_SEL_ERR_EN.
package qpmux_sel_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_OFF = 2'd1,
    SWITCH   = 2'd2,
    SETTLE   = 2'd3
  } state_t;

  localparam logic [1:0] SRC_QCLKIN = 2'd0;
  localparam logic [1:0] SRC_QHSCK  = 2'd1;
  localparam logic [1:0] SRC_GMUXIN = 2'd2;
  localparam logic [1:0] SRC_RSVD   = 2'd3;

  // Map a source code to the mux select pins, returned as {IS1, IS0}.
  // The reserved code maps like QHSCK so both select bits are never set.
  function automatic logic [1:0] src_to_is(input logic [1:0] sel);
    logic [1:0] is_bits;
    case (sel)
      SRC_QCLKIN: is_bits = 2'b00;
      SRC_QHSCK:  is_bits = 2'b10;
      SRC_GMUXIN: is_bits = 2'b01;
      default:    is_bits = 2'b10;
    endcase
    return is_bits;
  endfunction

endpackage

// File: rtl/qpmux_sel_timer.sv
// Loadable down-counter used to time the gate-off and settle windows.
// hit flags a count of 1, i.e. the last cycle of the current window.
module qpmux_sel_timer #(
  parameter int CNT_W   = 8,
  parameter int RST_VAL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] value,
  output logic             hit
);

  logic [CNT_W-1:0] count;

  // Load has priority over decrement; reset preloads the settle window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= CNT_W'(RST_VAL);
    end else if (load) begin
      count <= value;
    end else if (en) begin
      count <= count - 1'b1;
    end
  end

  assign hit = (count == CNT_W'(1));

endmodule

// File: rtl/qpmux_sel_ctrl.sv
// Break-before-make select sequencer for the quad-clock mux cell.
// Sequence on a source change: gate off, hold, change select, settle, gate on.
// Optional macro QPMUX_SEL_ERR_EN: reject the reserved source code and raise
// a sticky ERR flag instead of treating it as QHSCK.
//
// Request handshake: a request is taken on a rising CLK edge where REQ_VALID
// and REQ_READY are both high. REQ_READY is high only in IDLE; a requester
// holds REQ_VALID and REQ_SEL stable until that edge.
module qpmux_sel_ctrl
  import qpmux_sel_pkg::*;
#(
  parameter int OFF_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_VALID,
  input  logic [1:0] REQ_SEL,
  output logic       REQ_READY,
  output logic       IS0,
  output logic       IS1,
  output logic       GATE_EN,
  output logic       BUSY,
  output logic       DONE,
  output logic [1:0] CUR_SEL
`ifdef QPMUX_SEL_ERR_EN
  ,
  output logic       ERR
`endif
);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       tgt_sel;
  logic [1:0]       tgt_sel_nxt;
  logic [1:0]       cur_sel_nxt;
  logic             gate_nxt;
  logic             done_nxt;
  logic             in_seq;
  logic             in_seq_nxt;
  logic             t_load;
  logic             t_en;
  logic [CNT_W-1:0] t_value;
  logic             t_hit;
  logic [1:0]       sel_eff;
  logic             rsvd_req;

`ifdef QPMUX_SEL_ERR_EN
  assign sel_eff  = REQ_SEL;
  assign rsvd_req = (REQ_SEL == SRC_RSVD);
`else
  assign sel_eff  = (REQ_SEL == SRC_RSVD) ? SRC_QHSCK : REQ_SEL;
  assign rsvd_req = 1'b0;
`endif

  assign REQ_READY = (state == IDLE);
  assign BUSY      = (state != IDLE);

  qpmux_sel_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(SETTLE_CYCLES)
  ) u_timer (
    .clk  (CLK),
    .rst  (RST),
    .load (t_load),
    .en   (t_en),
    .value(t_value),
    .hit  (t_hit)
  );

  // State register plus all registered outputs; reset lands in SETTLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= SETTLE;
      tgt_sel    <= SRC_QCLKIN;
      CUR_SEL    <= SRC_QCLKIN;
      {IS1, IS0} <= 2'b00;
      GATE_EN    <= 1'b0;
      DONE       <= 1'b0;
      in_seq     <= 1'b0;
    end else begin
      state      <= state_nxt;
      tgt_sel    <= tgt_sel_nxt;
      CUR_SEL    <= cur_sel_nxt;
      {IS1, IS0} <= src_to_is(cur_sel_nxt);
      GATE_EN    <= gate_nxt;
      DONE       <= done_nxt;
      in_seq     <= in_seq_nxt;
    end
  end

  // Next-state and next-output decode; select only moves in SWITCH while
  // the gate is already low, so select and gate never change together.
  always_comb begin
    state_nxt   = state;
    tgt_sel_nxt = tgt_sel;
    cur_sel_nxt = CUR_SEL;
    gate_nxt    = 1'b0;
    done_nxt    = 1'b0;
    in_seq_nxt  = in_seq;
    t_load      = 1'b0;
    t_en        = 1'b0;
    t_value     = '0;
    case (state)
      IDLE: begin
        gate_nxt = 1'b1;
        if (REQ_VALID && !rsvd_req) begin
          if (sel_eff == CUR_SEL) begin
            done_nxt = 1'b1;
          end else begin
            tgt_sel_nxt = sel_eff;
            t_load      = 1'b1;
            t_value     = CNT_W'(OFF_CYCLES);
            state_nxt   = GATE_OFF;
            gate_nxt    = 1'b0;
            in_seq_nxt  = 1'b1;
          end
        end
      end
      GATE_OFF: begin
        if (t_hit) begin
          state_nxt = SWITCH;
        end else begin
          t_en = 1'b1;
        end
      end
      SWITCH: begin
        cur_sel_nxt = tgt_sel;
        t_load      = 1'b1;
        t_value     = CNT_W'(SETTLE_CYCLES);
        state_nxt   = SETTLE;
      end
      SETTLE: begin
        if (t_hit) begin
          state_nxt  = IDLE;
          gate_nxt   = 1'b1;
          done_nxt   = in_seq;
          in_seq_nxt = 1'b0;
        end else begin
          t_en = 1'b1;
        end
      end
      default: begin
        state_nxt = SETTLE;
      end
    endcase
  end

`ifdef QPMUX_SEL_ERR_EN
  // Sticky flag for a reserved request taken in IDLE; cleared only by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ERR <= 1'b0;
    end else if (state == IDLE && REQ_VALID && rsvd_req) begin
      ERR <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_qpmux_sel_ctrl.sv
// Self-checking bench for qpmux_sel_ctrl, default and QPMUX_SEL_ERR_EN builds.
module tb_qpmux_sel_ctrl;

  localparam int OFF = 4;
  localparam int SET = 8;
  localparam int TOT = OFF + 1 + SET;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ_VALID = 1'b0;
  logic [1:0] REQ_SEL = 2'd0;
  logic       REQ_READY, IS0, IS1, GATE_EN, BUSY, DONE;
  logic [1:0] CUR_SEL;
`ifdef QPMUX_SEL_ERR_EN
  logic       ERR;
`endif

  int         n_checks = 0;
  int         n_fail = 0;
  logic [1:0] exp_sel = 2'd0;
  logic       err_exp = 1'b0;

  qpmux_sel_ctrl #(
    .OFF_CYCLES(OFF),
    .SETTLE_CYCLES(SET),
    .CNT_W(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .REQ_VALID(REQ_VALID),
    .REQ_SEL(REQ_SEL),
    .REQ_READY(REQ_READY),
    .IS0(IS0),
    .IS1(IS1),
    .GATE_EN(GATE_EN),
    .BUSY(BUSY),
    .DONE(DONE),
    .CUR_SEL(CUR_SEL)
`ifdef QPMUX_SEL_ERR_EN
    ,
    .ERR(ERR)
`endif
  );

  // Clock and reset
  always #5 CLK = ~CLK;

  // Source encoding table, returned as {IS1, IS0}.
  function automatic logic [1:0] exp_is(input logic [1:0] s);
    if (s == 2'd1) return 2'b10;
    if (s == 2'd2) return 2'b01;
    return 2'b00;
  endfunction

  // Checks every observable against the timeline of one request, for the
  // n cycles after the accepting edge; samples on the falling edge.
  task automatic trace(input string nm, input logic [1:0] old_s,
                       input logic [1:0] new_s, input bit change,
                       input bit is_err, input bit hold,
                       input logic [1:0] hold_sel, input int n);
    bit e_busy, e_gate, e_done;
    logic [1:0] e_sel;
    for (int j = 1; j <= n; j++) begin
      @(negedge CLK);
      if (j == 1) begin
        if (hold) REQ_SEL = hold_sel;
        else REQ_VALID = 1'b0;
      end
      if (change) begin
        e_busy = (j <= TOT);
        e_done = (j == TOT + 1);
        e_sel  = (j >= OFF + 2) ? new_s : old_s;
      end else begin
        e_busy = 1'b0;
        e_done = (j == 1) && !is_err;
        e_sel  = old_s;
      end
      e_gate = !e_busy;
      n_checks++;
      if (BUSY !== e_busy) begin
        n_fail++; $display("FAIL %s busy j=%0d got=%b exp=%b", nm, j, BUSY, e_busy);
      end
      n_checks++;
      if (REQ_READY !== !e_busy) begin
        n_fail++; $display("FAIL %s ready j=%0d got=%b exp=%b", nm, j, REQ_READY, !e_busy);
      end
      n_checks++;
      if (GATE_EN !== e_gate) begin
        n_fail++; $display("FAIL %s gate_en j=%0d got=%b exp=%b", nm, j, GATE_EN, e_gate);
      end
      n_checks++;
      if (DONE !== e_done) begin
        n_fail++; $display("FAIL %s done j=%0d got=%b exp=%b", nm, j, DONE, e_done);
      end
      n_checks++;
      if (CUR_SEL !== e_sel) begin
        n_fail++; $display("FAIL %s cur_sel j=%0d got=%0d exp=%0d", nm, j, CUR_SEL, e_sel);
      end
      n_checks++;
      if ({IS1, IS0} !== exp_is(e_sel)) begin
        n_fail++; $display("FAIL %s is1_is0 j=%0d got=%b exp=%b", nm, j, {IS1, IS0}, exp_is(e_sel));
      end
`ifdef QPMUX_SEL_ERR_EN
      n_checks++;
      if (ERR !== err_exp) begin
        n_fail++; $display("FAIL %s err j=%0d got=%b exp=%b", nm, j, ERR, err_exp);
      end
`endif
    end
  endtask

  // Driver: present one request in IDLE, then follow it with the model.
  task automatic do_req(input string nm, input logic [1:0] sel,
                        input bit hold, input logic [1:0] hold_sel, input int n);
    logic [1:0] eff;
    bit is_err, change;
    eff = sel;
    is_err = 1'b0;
    if (sel == 2'd3) begin
`ifdef QPMUX_SEL_ERR_EN
      is_err = 1'b1;
`else
      eff = 2'd1;
`endif
    end
    change = !is_err && (eff != exp_sel);
    @(negedge CLK);
    REQ_VALID = 1'b1;
    REQ_SEL = sel;
    n_checks++;
    if (REQ_READY !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_idle got=%b exp=1", nm, REQ_READY);
    end
    @(posedge CLK);
    if (is_err) err_exp = 1'b1;
    trace(nm, exp_sel, eff, change, is_err, hold, hold_sel,
          (n > 0) ? n : (change ? TOT + 2 : 2));
    if (change) exp_sel = eff;
  endtask

  task automatic check_in_reset(input string nm);
    n_checks++;
    if ({IS1, IS0, CUR_SEL, GATE_EN, DONE, REQ_READY, BUSY} !== 8'b0000_0001) begin
      n_fail++;
      $display("FAIL %s reset_vals got=is%b cur%0d gate%b done%b rdy%b busy%b exp=is00 cur0 gate0 done0 rdy0 busy1",
               nm, {IS1, IS0}, CUR_SEL, GATE_EN, DONE, REQ_READY, BUSY);
    end
`ifdef QPMUX_SEL_ERR_EN
    n_checks++;
    if (ERR !== 1'b0) begin
      n_fail++; $display("FAIL %s reset_err got=%b exp=0", nm, ERR);
    end
`endif
  endtask

  // After release the block runs one settle window, then idles with no DONE.
  task automatic recover(input string nm);
    @(negedge CLK);
    RST = 1'b0;
    exp_sel = 2'd0;
    err_exp = 1'b0;
    for (int j = 1; j <= SET + 1; j++) begin
      @(negedge CLK);
      n_checks++;
      if (BUSY !== (j < SET) || GATE_EN !== (j >= SET) || DONE !== 1'b0 ||
          {IS1, IS0} !== 2'b00 || CUR_SEL !== 2'd0) begin
        n_fail++;
        $display("FAIL %s recover j=%0d got=busy%b gate%b done%b is%b cur%0d exp=busy%b gate%b done0 is00 cur0",
                 nm, j, BUSY, GATE_EN, DONE, {IS1, IS0}, CUR_SEL, j < SET, j >= SET);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_in_reset("reset");
    recover("reset");
  endtask

  task automatic test_switch();
    if (exp_sel == 2'd2) do_req("switch_pre", 2'd0, 1'b0, 2'd0, 0);
    do_req("switch_to_gmuxin", 2'd2, 1'b0, 2'd0, 0);
  endtask

  task automatic test_same_sel();
    do_req("same_sel", exp_sel, 1'b0, 2'd0, 0);
  endtask

  task automatic test_back_to_back();
    logic [1:0] t;
    t = (exp_sel == 2'd2) ? 2'd0 : 2'd2;
    do_req("held_first", t, 1'b1, 2'd1, TOT + 1);
    exp_sel = t;
    @(posedge CLK);
    trace("held_second", t, 2'd1, 1'b1, 1'b0, 1'b0, 2'd0, TOT + 2);
    exp_sel = 2'd1;
  endtask

  task automatic test_reserved();
    if (exp_sel == 2'd1) do_req("rsvd_pre", 2'd0, 1'b0, 2'd0, 0);
    do_req("reserved", 2'd3, 1'b0, 2'd0, 0);
  endtask

  // Reset mid-sequence of a 0->2 change, n cycles after the accept edge.
  task automatic test_reset_mid(input string nm, input int n);
    if (exp_sel == 2'd2) do_req("mid_pre", 2'd0, 1'b0, 2'd0, 0);
    if (exp_sel != 2'd0) do_req("mid_pre0", 2'd0, 1'b0, 2'd0, 0);
    do_req(nm, 2'd2, 1'b0, 2'd0, n);
    RST = 1'b1;
    #1;
    check_in_reset(nm);
    recover(nm);
  endtask

  task automatic test_random();
    logic [1:0] s;
    for (int i = 0; i < 10; i++) begin
      s = 2'($urandom_range(0, 3));
      do_req("random", s, 1'b0, 2'd0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_switch();
    test_same_sel();
    test_back_to_back();
    test_reserved();
    test_reset_mid("rst_in_switch", OFF + 1);
    test_reset_mid("rst_in_settle", OFF + 4);
    test_random();
    test_same_sel();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
